// File: rtl/alu_exec.sv
// alu_exec: single-stage ALU execute with an architectural flag register
// {c,o,s,z} and a valid/ready output buffer.
// Build option: define ALU_EXEC_SKID_EN for a 2-entry output buffer with a
// registered in_ready. Leave it undefined for a single output register with
// a combinational ready pass-through.
module alu_exec (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [17:0] in_s1,
   input  logic [17:0] in_s2,
   input  logic [3:0]  in_rd,
   input  logic        in_setf,
   input  logic        flags_wr,
   input  logic [3:0]  flags_wdata,
   output logic [3:0]  flags,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [17:0] out_res,
   output logic [3:0]  out_rd,
   output logic [3:0]  out_flags
);

   typedef enum logic [2:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_XOR   = 3'd2,
      OP_SETHI = 3'd3,
      OP_ADD   = 3'd4,
      OP_SUB   = 3'd5,
      OP_ADDC  = 3'd6,
      OP_SUBC  = 3'd7
   } op_e;

   op_e         op;
   logic [17:0] b_opnd;
   logic        carry_in;
   logic        arith;
   logic [18:0] sum;
   logic        carry;
   logic        ovf;
   logic [17:0] new_res;
   logic [3:0]  new_flags;
   logic        accept;
   logic        consume;

   assign op      = op_e'(in_op);
   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   // Result and flags of the offered op; subtraction is s1 + ~s2 + carry-in
   always_comb begin
      b_opnd   = in_s2;
      carry_in = 1'b0;
      arith    = 1'b0;
      sum      = '0;
      carry    = 1'b0;
      ovf      = 1'b0;
      new_res  = '0;
      case (op)
         OP_AND:   new_res = in_s1 & in_s2;
         OP_OR:    new_res = in_s1 | in_s2;
         OP_XOR:   new_res = in_s1 ^ in_s2;
         OP_SETHI: new_res = {in_s2[17:9], in_s1[8:0]};
         OP_ADD:   arith = 1'b1;
         OP_SUB: begin
            arith    = 1'b1;
            b_opnd   = ~in_s2;
            carry_in = 1'b1;
         end
         OP_ADDC: begin
            arith    = 1'b1;
            carry_in = flags[3];
         end
         OP_SUBC: begin
            arith    = 1'b1;
            b_opnd   = ~in_s2;
            carry_in = flags[3];
         end
         default:  new_res = '0;
      endcase
      if (arith) begin
         sum     = {1'b0, in_s1} + {1'b0, b_opnd} + {18'd0, carry_in};
         new_res = sum[17:0];
         carry   = sum[18];
         ovf     = (in_s1[17] == b_opnd[17]) & (new_res[17] != in_s1[17]);
      end
      new_flags = {carry, ovf, new_res[17], (new_res == 18'd0)};
   end

   // Flag register: a direct write overrides a same-edge flag-setting op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= '0;
      end else if (flags_wr) begin
         flags <= flags_wdata;
      end else if (accept && in_setf) begin
         flags <= new_flags;
      end
   end

`ifdef ALU_EXEC_SKID_EN
   logic        skid_valid;
   logic [17:0] skid_res;
   logic [3:0]  skid_rd;
   logic [3:0]  skid_flags;
   logic        out_valid_next;
   logic        skid_valid_next;
   logic        load_out;
   logic        move_skid;
   logic        load_skid;

   // Occupancy and data-movement decisions for the two-entry buffer
   always_comb begin
      out_valid_next  = out_valid;
      skid_valid_next = skid_valid;
      if (accept && !consume) begin
         if (out_valid) begin
            skid_valid_next = 1'b1;
         end else begin
            out_valid_next = 1'b1;
         end
      end else if (consume && !accept) begin
         if (skid_valid) begin
            skid_valid_next = 1'b0;
         end else begin
            out_valid_next = 1'b0;
         end
      end
      move_skid = consume & skid_valid;
      load_out  = accept & (consume ? ~skid_valid : ~out_valid);
      load_skid = accept & ((consume & skid_valid) | (~consume & out_valid));
   end

   // Buffer state; in_ready is registered from the next occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
         out_res    <= '0;
         out_rd     <= '0;
         out_flags  <= '0;
         skid_res   <= '0;
         skid_rd    <= '0;
         skid_flags <= '0;
      end else begin
         out_valid  <= out_valid_next;
         skid_valid <= skid_valid_next;
         in_ready   <= ~(out_valid_next & skid_valid_next);
         if (move_skid) begin
            out_res   <= skid_res;
            out_rd    <= skid_rd;
            out_flags <= skid_flags;
         end else if (load_out) begin
            out_res   <= new_res;
            out_rd    <= in_rd;
            out_flags <= new_flags;
         end
         if (load_skid) begin
            skid_res   <= new_res;
            skid_rd    <= in_rd;
            skid_flags <= new_flags;
         end
      end
   end
`else
   assign in_ready = ~out_valid | out_ready;

   // Single output register; an accept replaces whatever is being consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_res   <= '0;
         out_rd    <= '0;
         out_flags <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_res   <= new_res;
         out_rd    <= in_rd;
         out_flags <= new_flags;
      end else if (consume) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule
